// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Covers the loader FSM encoding, the frame layout and the header range check.
package inst_loader_pkg;

  localparam int LOAD_HDR_BYTES  = 2;
  localparam int LOAD_WORD_BYTES = 4;
  localparam int IM_ADDR_W       = 10;

  typedef logic [31:0]          inst_t;
  typedef logic [IM_ADDR_W-1:0] im_addr_t;

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_WORD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } loader_state_e;

  // True when a header word count cannot fit in an instruction memory of 'limit' words.
  function automatic logic count_exceeds(input logic [15:0] n, input int unsigned limit);
    return {16'd0, n} > limit;
  endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Big-endian 4-byte shift register that builds one instruction from the byte stream.
// word_full marks that the next shifted byte completes the word.
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [7:0] byte_in,
  output inst_t      word,
  output logic       word_full
);

  inst_t      shreg_r;
  logic [1:0] bidx_r;

  // Shift register and byte index; the 2-bit index wraps to zero after the 4th byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_r <= 32'd0;
      bidx_r  <= 2'd0;
    end else if (clr) begin
      shreg_r <= 32'd0;
      bidx_r  <= 2'd0;
    end else if (shift_en) begin
      shreg_r <= {shreg_r[23:0], byte_in};
      bidx_r  <= bidx_r + 2'd1;
    end else begin
      shreg_r <= shreg_r;
      bidx_r  <= bidx_r;
    end
  end

  assign word      = shreg_r;
  assign word_full = (bidx_r == 2'(LOAD_WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// Frame loader: header word count, then big-endian instructions written one per en pulse.
// Keeps the core in reset until the frame is complete plus a short release delay.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int IM_DEPTH      = 1024,
  parameter int ADDR_W        = 10,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              en,
  output logic [31:0]       outer_inst,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [3:0]        DLY_LAST = 4'(RELEASE_DELAY - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  loader_state_e     state_r;
  logic [15:0]       cnt_r;
  logic [15:0]       words_r;
  logic [3:0]        dly_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic              byte_ready_r;
  logic              en_r;
  logic              core_rst_n_r;
  logic              load_done_r;
  logic              load_err_r;

  logic              xfer_s;
  logic [15:0]       hdr_s;
  logic              asm_clr_s;
  logic              asm_shift_s;
  logic              word_full_s;
  inst_t             asm_word_s;

  assign xfer_s      = byte_valid & byte_ready_r;
  assign hdr_s       = {cnt_r[15:8], byte_data};
  assign asm_clr_s   = xfer_s && (state_r == S_HDR1);
  assign asm_shift_s = xfer_s && (state_r == S_WORD);

  byte_assembler u_asm (
    .clk       (cpu_clk_50M),
    .rst_n     (cpu_rst_n),
    .clr       (asm_clr_s),
    .shift_en  (asm_shift_s),
    .byte_in   (byte_data),
    .word      (asm_word_s),
    .word_full (word_full_s)
  );

  // Loader FSM with word counter, release-delay counter and all registered outputs.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_r      <= S_HDR0;
      cnt_r        <= 16'd0;
      words_r      <= 16'd0;
      dly_r        <= 4'd0;
      wr_addr_r    <= '0;
      byte_ready_r <= 1'b0;
      en_r         <= 1'b0;
      core_rst_n_r <= 1'b0;
      load_done_r  <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      en_r <= 1'b0;
      case (state_r)
        S_HDR0: begin
          byte_ready_r <= 1'b1;
          if (xfer_s) begin
            cnt_r[15:8] <= byte_data;
            state_r     <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer_s) begin
            cnt_r[7:0] <= byte_data;
            wr_addr_r  <= '0;
            words_r    <= 16'd0;
            if (hdr_s == 16'd0) begin
              state_r      <= S_DONE;
              byte_ready_r <= 1'b0;
              load_done_r  <= 1'b1;
              dly_r        <= 4'd0;
            end else if (count_exceeds(hdr_s, IM_DEPTH)) begin
              state_r      <= S_ERR;
              byte_ready_r <= 1'b0;
              load_err_r   <= 1'b1;
            end else begin
              state_r <= S_WORD;
            end
          end
        end
        S_WORD: begin
          // The write strobe is raised on the same edge that takes the 4th byte.
          if (xfer_s && word_full_s) begin
            state_r      <= S_WRITE;
            byte_ready_r <= 1'b0;
            en_r         <= 1'b1;
          end
        end
        S_WRITE: begin
          if (words_r == cnt_r - 16'd1) begin
            state_r     <= S_DONE;
            load_done_r <= 1'b1;
            dly_r       <= 4'd0;
          end else begin
            state_r      <= S_WORD;
            byte_ready_r <= 1'b1;
            wr_addr_r    <= wr_addr_r + ADDR_ONE;
            words_r      <= words_r + 16'd1;
          end
        end
        S_DONE: begin
          if (load_start) begin
            state_r      <= S_HDR0;
            byte_ready_r <= 1'b1;
            load_done_r  <= 1'b0;
            core_rst_n_r <= 1'b0;
            wr_addr_r    <= '0;
          end else if (!core_rst_n_r) begin
            if (dly_r == DLY_LAST) begin
              core_rst_n_r <= 1'b1;
            end else begin
              dly_r <= dly_r + 4'd1;
            end
          end
        end
        S_ERR: begin
          core_rst_n_r <= 1'b0;
          if (load_start) begin
            state_r      <= S_HDR0;
            byte_ready_r <= 1'b1;
            load_err_r   <= 1'b0;
            wr_addr_r    <= '0;
          end
        end
        default: begin
          state_r      <= S_HDR0;
          byte_ready_r <= 1'b0;
          core_rst_n_r <= 1'b0;
          load_done_r  <= 1'b0;
          load_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign en         = en_r;
  assign outer_inst = asm_word_s;
  assign wr_addr    = wr_addr_r;
  assign core_rst_n = core_rst_n_r;
  assign load_done  = load_done_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: frames are built from a word list, expected writes
// are queued when a frame is built and a monitor pops them on every en pulse.
module tb_inst_loader;

  localparam int IM_DEPTH = 1024;
  localparam int ADDR_W   = 10;
  localparam int RD       = 4;

  logic              clk = 1'b0;
  logic              cpu_rst_n;
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              en;
  logic [31:0]       outer_inst;
  logic [ADDR_W-1:0] wr_addr;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int en_seen = 0;
  int t_done = -1;
  int t_rel  = -1;
  logic prev_done = 1'b0;
  logic prev_rel  = 1'b0;

  logic [31:0] exp_inst_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [7:0]  bytes_q[$];
  logic [31:0] words_q[$];

  inst_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W), .RELEASE_DELAY(RD)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (cpu_rst_n),
    .load_start  (load_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .en          (en),
    .outer_inst  (outer_inst),
    .wr_addr     (wr_addr),
    .core_rst_n  (core_rst_n),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every en cycle is matched against the head of the expected-write queue.
  initial begin
    forever begin
      @(negedge clk);
      if (en === 1'b1) begin
        en_seen++;
        chk("en_while_core_released", {31'd0, core_rst_n}, 32'd0);
        chk("ready_during_write", {31'd0, byte_ready}, 32'd0);
        if (exp_inst_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got 0x%08h at addr %0d, expected no write", outer_inst, wr_addr);
        end else begin
          chk("outer_inst", outer_inst, exp_inst_q.pop_front());
          chk("wr_addr", {22'd0, wr_addr}, {22'd0, exp_addr_q.pop_front()});
        end
      end
      if (load_done && !prev_done) t_done = cyc;
      if (core_rst_n && !prev_rel) t_rel = cyc;
      prev_done = load_done;
      prev_rel  = core_rst_n;
    end
  end

  // Reference model: a frame of n words writes words_q[i] (or a random word) at address i.
  task automatic build_frame(input int n);
    logic [15:0] n16;
    logic [31:0] w;
    n16 = 16'(n);
    bytes_q.delete();
    en_seen = 0;
    t_done  = -1;
    t_rel   = -1;
    bytes_q.push_back(n16[15:8]);
    bytes_q.push_back(n16[7:0]);
    if (n >= 1 && n <= IM_DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = (i < words_q.size()) ? words_q[i] : $urandom;
        bytes_q.push_back(w[31:24]);
        bytes_q.push_back(w[23:16]);
        bytes_q.push_back(w[15:8]);
        bytes_q.push_back(w[7:0]);
        exp_inst_q.push_back(w);
        exp_addr_q.push_back(10'(i));
      end
    end
    words_q.delete();
  endtask

  // Drive bytes_q; mode 0 = valid always, 1 = toggling, 2 = random gaps plus stray load_start.
  task automatic send_bytes(input int mode);
    int   guard;
    logic v;
    guard = 0;
    while (bytes_q.size() > 0) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      byte_valid = v;
      byte_data  = v ? bytes_q[0] : 8'($urandom);
      load_start = (mode == 2) && ($urandom_range(0, 7) == 0);
      if (v && byte_ready) begin
        void'(bytes_q.pop_front());
        guard = 0;
      end else begin
        guard++;
        if (guard > 100) begin
          tests++;
          fails++;
          $display("FAIL byte_accept_timeout: got byte_ready=%0b for 100 cycles, expected 1", byte_ready);
          bytes_q.delete();
        end
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic finish_frame(input bit ok, input int nwr);
    int g;
    g = 0;
    while (!(load_done || load_err) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("frame_status", {30'd0, load_done, load_err}, ok ? 32'd2 : 32'd1);
    chk("pending_writes", exp_inst_q.size(), 32'd0);
    chk("write_count", en_seen, nwr);
    if (ok) begin
      g = 0;
      while (!core_rst_n && g < 40) begin
        @(negedge clk);
        g++;
      end
      @(negedge clk);
      chk("core_released", {31'd0, core_rst_n}, 32'd1);
      chk("release_delay", t_rel - t_done, RD);
    end else begin
      repeat (8) @(negedge clk);
      chk("err_core_held", {31'd0, core_rst_n}, 32'd0);
      chk("err_not_ready", {31'd0, byte_ready}, 32'd0);
      chk("err_sticky", {31'd0, load_err}, 32'd1);
    end
    exp_inst_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic restart();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("restart_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("restart_ready", {31'd0, byte_ready}, 32'd1);
    chk("restart_flags", {30'd0, load_done, load_err}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"}, {31'd0, en}, 32'd0);
    chk({tag, "_outer_inst"}, outer_inst, 32'd0);
    chk({tag, "_wr_addr"}, {22'd0, wr_addr}, 32'd0);
    chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    chk({tag, "_flags"}, {30'd0, load_done, load_err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
  endtask

  initial begin
    cpu_rst_n  = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    cpu_rst_n = 1'b1;

    // Two-word frame, continuous valid.
    words_q = '{32'h24010005, 32'h24020007};
    build_frame(2);
    send_bytes(0);
    finish_frame(1'b1, 2);

    // Same frame with toggling valid.
    restart();
    words_q = '{32'h24010005, 32'h24020007};
    build_frame(2);
    send_bytes(1);
    finish_frame(1'b1, 2);

    // Empty frame.
    restart();
    build_frame(0);
    send_bytes(0);
    chk("n0_done_immediate", {31'd0, load_done}, 32'd1);
    finish_frame(1'b1, 0);

    // Count one past the memory depth.
    restart();
    build_frame(IM_DEPTH + 1);
    send_bytes(0);
    chk("overflow_err_immediate", {31'd0, load_err}, 32'd1);
    finish_frame(1'b0, 0);
    restart();

    // Reset in the middle of the first word of a 3-word frame.
    en_seen = 0;
    bytes_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_bytes(0);
    cpu_rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midload_reset");
    chk("midload_no_write", en_seen, 32'd0);
    cpu_rst_n = 1'b1;
    words_q = '{32'hDEADBEEF};
    build_frame(1);
    send_bytes(0);
    finish_frame(1'b1, 1);

    // Reload after the core was released.
    restart();
    words_q = '{32'h00000000};
    build_frame(1);
    send_bytes(0);
    finish_frame(1'b1, 1);

    // Random frames with random valid gaps.
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 8);
      restart();
      build_frame(n);
      send_bytes($urandom_range(0, 2));
      finish_frame(1'b1, n);
    end

    // Full-depth frame: last write lands at IM_DEPTH-1.
    restart();
    build_frame(IM_DEPTH);
    send_bytes(0);
    finish_frame(1'b1, IM_DEPTH);
    chk("full_depth_no_wrap", {22'd0, wr_addr}, 32'(IM_DEPTH - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
